// File: rtl/mvu_ic_pkg.sv
// Shared definitions for the MVU interconnect: select/occupancy width helpers,
// default sizes and the data-bank word type.
package mvu_ic_pkg;

  localparam int unsigned NMVU_DEF       = 8;
  localparam int unsigned DBANK_W        = 64;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned DROP_W         = 16;

  typedef logic [DBANK_W-1:0] word_t;

  function automatic int unsigned sel_width(input int unsigned nmvu);
    return $clog2(nmvu);
  endfunction

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned BMVUA_DEF = sel_width(NMVU_DEF);

endpackage

// File: rtl/ic_fifo.sv
// Per-destination first-word-fall-through FIFO; pointers carry one extra wrap
// bit so full/empty come straight from pointer comparison.
module ic_fifo
  import mvu_ic_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned BOCC = occ_width(DEPTH),
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [BOCC-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [BOCC-1:0]  wptr_q, wptr_d;
  logic [BOCC-1:0]  rptr_q, rptr_d;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[BOCC-1] != rptr_q[BOCC-1]) &&
                 (wptr_q[BOCC-2:0] == rptr_q[BOCC-2:0]);
  assign count = wptr_q - rptr_q;
  // Gate the head with empty so stale or never-written storage is never visible.
  assign dout  = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wptr_q[AW-1:0]] = din;
        wptr_d = wptr_q + BOCC'(1);
      end
      if (pop && !empty) begin
        rptr_d = rptr_q + BOCC'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ic_xbar_fifo.sv
// Multicast MVU crossbar with one buffered FIFO per destination and a latched
// route register. Optional per-source drop counters: IC_XBAR_DROPCNT_EN.
module ic_xbar_fifo
  import mvu_ic_pkg::*;
#(
  parameter int unsigned NMVU       = NMVU_DEF,
  parameter int unsigned BDBANKW    = DBANK_W,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned BMVUA     = sel_width(NMVU),
  localparam int unsigned BOCC      = occ_width(FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ic_clr,
  input  logic                      cfg_load,
  input  logic [NMVU*BMVUA-1:0]     recv_from,
  input  logic [NMVU-1:0]           send_en,
  input  logic [NMVU*BDBANKW-1:0]   send_word,
  output logic [NMVU-1:0]           send_rdy,
  output logic [NMVU-1:0]           recv_en,
  output logic [NMVU*BDBANKW-1:0]   recv_word,
  input  logic [NMVU-1:0]           recv_rdy,
  output logic [NMVU*BOCC-1:0]      occupancy
`ifdef IC_XBAR_DROPCNT_EN
  ,
  output logic [NMVU*DROP_W-1:0]    drop_cnt
`endif
);

  logic [BMVUA-1:0]   route_q [NMVU];
  logic [BMVUA-1:0]   route_d [NMVU];
  logic [BDBANKW-1:0] src_word [NMVU];
  logic [BDBANKW-1:0] din [NMVU];
  logic [NMVU-1:0]    push;
  logic [NMVU-1:0]    accept;
  logic [NMVU-1:0]    fifo_full;
  logic [NMVU-1:0]    fifo_empty;

  always_comb begin
    route_d = route_q;
    if (cfg_load) begin
      for (int unsigned d = 0; d < NMVU; d++) begin
        route_d[d] = recv_from[d*BMVUA +: BMVUA];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned d = 0; d < NMVU; d++) begin
        route_q[d] <= BMVUA'(d);
      end
    end else begin
      route_q <= route_d;
    end
  end

  // A source is ready only if every subscriber has room; a pop in the same
  // cycle is deliberately ignored so ready never depends on recv_rdy.
  always_comb begin
    send_rdy = '1;
    for (int unsigned d = 0; d < NMVU; d++) begin
      if (fifo_full[d]) begin
        send_rdy[route_q[d]] = 1'b0;
      end
    end
    accept = send_en & send_rdy;
    for (int unsigned d = 0; d < NMVU; d++) begin
      push[d] = accept[route_q[d]];
      din[d]  = src_word[route_q[d]];
    end
  end

  assign recv_en = ~fifo_empty;

  for (genvar g = 0; g < NMVU; g++) begin : g_dest
    assign src_word[g] = send_word[g*BDBANKW +: BDBANKW];

    ic_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BDBANKW)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (ic_clr),
      .push  (push[g]),
      .din   (din[g]),
      .pop   (recv_rdy[g]),
      .dout  (recv_word[g*BDBANKW +: BDBANKW]),
      .empty (fifo_empty[g]),
      .full  (fifo_full[g]),
      .count (occupancy[g*BOCC +: BOCC])
    );
  end

`ifdef IC_XBAR_DROPCNT_EN
  logic [NMVU-1:0]   has_sub;
  logic [DROP_W-1:0] drop_q [NMVU];
  logic [DROP_W-1:0] drop_d [NMVU];

  always_comb begin
    has_sub = '0;
    for (int unsigned d = 0; d < NMVU; d++) begin
      has_sub[route_q[d]] = 1'b1;
    end
    drop_d = drop_q;
    if (ic_clr) begin
      for (int unsigned s = 0; s < NMVU; s++) begin
        drop_d[s] = '0;
      end
    end else begin
      for (int unsigned s = 0; s < NMVU; s++) begin
        if (accept[s] && !has_sub[s] && (drop_q[s] != '1)) begin
          drop_d[s] = drop_q[s] + DROP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NMVU; s++) begin
        drop_q[s] <= '0;
      end
    end else begin
      drop_q <= drop_d;
    end
  end

  for (genvar g = 0; g < NMVU; g++) begin : g_drop
    assign drop_cnt[g*DROP_W +: DROP_W] = drop_q[g];
  end
`endif

endmodule

// File: doc/ic_xbar_fifo.md
Name: ic_xbar_fifo

Overview:
- Second-generation MVU interconnect, parametrised in MVU count, word width and buffer depth.
- Source MVU i offers a data-bank word. Every destination whose latched route selects i receives a copy (multicast).
- Each destination has its own FIFO with ready/valid backpressure, so a stalled receiver no longer loses words.
- Sits between the per-MVU interconnect read port (send side) and interconnect write port (receive side) at the top level.

Parameters:
- NMVU, 8, number of MVUs; >=2, power of 2.
- BDBANKW, 64, word width in bits.
- FIFO_DEPTH, 4, entries per destination FIFO; >=2, power of 2.
- BMVUA, $clog2(NMVU), localparam, source-select width.
- BOCC, $clog2(FIFO_DEPTH)+1, localparam, occupancy width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ic_clr  in  1  flush all FIFOs; routing unchanged.
- cfg_load  in  1  latch recv_from into the route register.
- recv_from  in  NMVU*BMVUA  source select per destination; slice d selects the source for destination d.
- send_en  in  NMVU  source valid.
- send_word  in  NMVU*BDBANKW  source words.
- send_rdy  out  NMVU  source accepted this cycle if send_en is also high.
- recv_en  out  NMVU  destination valid (FIFO non-empty).
- recv_word  out  NMVU*BDBANKW  FIFO head word.
- recv_rdy  in  NMVU  destination pops the head when recv_en is also high.
- occupancy  out  NMVU*BOCC  per-destination entry count.

Behaviour:
- Reset (rst=1, sampled on clk rising edge):
  - All FIFOs empty.
  - recv_en=0, recv_word=0, occupancy=0.
  - Route register set to identity (destination d <- source d).
  - send_rdy follows the combinational rule below (all 1 after reset).
- Route register:
  - Written only when cfg_load=1; holds otherwise.
  - Takes effect from the cycle after cfg_load.
  - cfg_load and a transfer in the same cycle: the transfer uses the old route.
- Subscriber set: sub(s) = {d : route[d]==s}.
- send_rdy[s]:
  - = AND over d in sub(s) of !full[d].
  - Empty sub(s) -> send_rdy[s]=1 and an accepted word is discarded.
  - A full FIFO does not count a same-cycle pop as free space, so send_rdy[s] has no combinational path from recv_rdy.
- Push:
  - On send_en[s] & send_rdy[s], the word is written into every FIFO in sub(s) in the same cycle (atomic multicast).
  - No partial multicast: either all subscribers receive the word or none do.
  - Each destination has exactly one source, so there is no write contention.
- Latency:
  - Word accepted at edge t appears at recv_word / recv_en=1 after edge t (first-word-fall-through, registered).
  - Minimum one cycle source-to-destination.
- Pop: on recv_en[d] & recv_rdy[d]. recv_rdy while empty is ignored.
- Simultaneous push and pop on a non-full FIFO: occupancy unchanged, order preserved.
- Ordering: strict FIFO order per destination.
- Pointers:
  - Read/write pointers are BOCC bits wide and wrap modulo 2*FIFO_DEPTH.
  - full = pointer MSBs differ and remaining bits equal.
  - empty = pointers equal.
- ic_clr:
  - Empties all FIFOs at the next edge; recv_en=0 the following cycle.
  - Pushes and pops in the same cycle are discarded.
  - Takes priority over push/pop; rst takes priority over ic_clr.
- Reset mid-transfer: in-flight and buffered words are lost. No output X after reset.

Optional Feature:
- Macro: IC_XBAR_DROPCNT_EN.
- Defined:
  - Adds output drop_cnt, NMVU*16 bits: per-source saturating count of accepted words with empty sub(s).
  - Counts hold at 16'hFFFF once saturated.
  - Cleared by rst or ic_clr.
- Undefined: port absent, discarded words are silent, no counter logic.

Decomposition:
- Package mvu_ic_pkg:
  - BMVUA computation.
  - Word typedef logic [BDBANKW-1:0].
  - Occupancy width function.
- Sub-module ic_fifo (parameters DEPTH, WIDTH):
  - Ports: clk, rst, clr, push, din, pop, dout, empty, full, count.
  - Instantiated NMVU times in a generate loop.
- Top level holds the route register, the subscriber/ready logic and the drop counters.

Test Plan:
- Reset, then send_en[3]=1 with word 64'hA5 (identity route) -> recv_en[3]=1 and recv_word[3]=64'hA5 one cycle later; all other recv_en=0.
- cfg_load with destinations 0, 1 and 5 routed to source 2; single push 64'h1234 -> destinations 0, 1 and 5 each receive 64'h1234 in the same cycle; occupancy of each =1.
- FIFO_DEPTH=4, destination 1 recv_rdy=0, source 1 pushes 5 words -> 4 accepted, send_rdy[1]=0 on the 5th. recv_rdy=1 for one cycle -> send_rdy[1]=1 on the next cycle; order preserved.
- Multicast to destinations 0 and 4 with destination 4 full -> send_rdy=0; nothing is written to destination 0 (no partial write).
- ic_clr asserted with 3 buffered words plus a same-cycle push -> occupancy=0 and recv_en=0 next cycle; the route register is retained.
- IC_XBAR_DROPCNT_EN defined, route moved so source 6 has no subscribers, 3 pushes -> send_rdy[6]=1 throughout, drop_cnt[6]=3; ic_clr -> 0.
